uart_baud_tick_gen: RTL and testbench

Runtime-programmable UART baud tick generator with fractional divisor, replacing the fixed-divisor generator. It sits between the system clock and the UART RX/TX engines. It produces two outputs: an oversample tick `o_os_tick` for the RX sampler, and a bit-rate tick `o_bit_tick` for the TX shifter. The divisor is reloadable glitch-free and the phase can be resynchronised to an RX start bit.

---
 rtl/uart_baud_tick_gen_if.sv | 31 +++
 rtl/uart_baud_tick_gen.sv | 112 +++++++++++
 tb/tb_uart_baud_tick_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_tick_gen_if.sv
// uart_baud_tick_gen_if
// Control/status bundle between a UART controller and the baud tick generator.
//   master : controller side, drives enable/resync/load and the new divisor,
//            observes ticks, config error, pending flag and active divisor.
//   slave  : tick generator side.
interface uart_baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              i_enable;
    logic              i_resync;
    logic              i_load;
    logic [DIV_W-1:0]  i_div_int;
    logic [FRAC_W-1:0] i_div_frac;
    logic              o_os_tick;
    logic              o_bit_tick;
    logic              o_cfg_err;
    logic              o_pending;
    logic [DIV_W-1:0]  o_div_int;
    logic [FRAC_W-1:0] o_div_frac;

    modport master (
        output i_enable, i_resync, i_load, i_div_int, i_div_frac,
        input  o_os_tick, o_bit_tick, o_cfg_err, o_pending, o_div_int, o_div_frac
    );

    modport slave (
        input  i_enable, i_resync, i_load, i_div_int, i_div_frac,
        output o_os_tick, o_bit_tick, o_cfg_err, o_pending, o_div_int, o_div_frac
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen
// Runtime-programmable UART baud tick generator with a fractional divisor.
// Produces an oversample tick for the RX sampler and a bit tick (every
// OVERSAMPLE oversample ticks) for the TX shifter.
// Ports:
//   i_clock  : system clock
//   i_reset  : synchronous, active-high reset
//   bus      : uart_baud_tick_gen_if.slave (enable, resync, divisor load,
//              ticks, config error, pending flag, active divisor read-back)
module uart_baud_tick_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 162,
    parameter int DEFAULT_FRAC = 12
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_baud_tick_gen_if.slave  bus
);
    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  lim;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] sh_frac;
    logic [OS_W-1:0]   os_cnt;
    logic              pending;
    logic              os_tick;
    logic              bit_tick;
    logic              cfg_err;

    logic [FRAC_W:0]   sum;
    logic [DIV_W-1:0]  next_int;
    logic [FRAC_W-1:0] next_frac;
    logic              wrap;
    logic              os_last;
    logic              load_ok;

    always_comb begin
        // Carry out of the fraction accumulator stretches the next period by one cycle.
        sum       = {1'b0, acc} + {1'b0, act_frac};
        // Divisor that becomes active at a wrap or resync.
        next_int  = pending ? sh_int  : act_int;
        next_frac = pending ? sh_frac : act_frac;
        // Resync overrides a simultaneous wrap.
        wrap      = bus.i_enable && !bus.i_resync && (cnt == lim);
        os_last   = (os_cnt == OS_W'(OVERSAMPLE - 1));
        load_ok   = (bus.i_div_int >= DIV_W'(2));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt      <= '0;
            lim      <= DIV_W'(DEFAULT_INT - 1);
            acc      <= '0;
            os_cnt   <= '0;
            act_int  <= DIV_W'(DEFAULT_INT);
            act_frac <= FRAC_W'(DEFAULT_FRAC);
            sh_int   <= DIV_W'(DEFAULT_INT);
            sh_frac  <= FRAC_W'(DEFAULT_FRAC);
            pending  <= 1'b0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            os_tick  <= wrap;
            bit_tick <= wrap && os_last;
            cfg_err  <= bus.i_load && !load_ok;

            if (bus.i_resync) begin
                cnt      <= '0;
                acc      <= '0;
                os_cnt   <= '0;
                act_int  <= next_int;
                act_frac <= next_frac;
                pending  <= 1'b0;
                lim      <= next_int - DIV_W'(1);
            end else if (bus.i_enable) begin
                if (!wrap) begin
                    cnt <= cnt + DIV_W'(1);
                end else begin
                    cnt      <= '0;
                    acc      <= sum[FRAC_W-1:0];
                    os_cnt   <= os_last ? '0 : os_cnt + OS_W'(1);
                    act_int  <= next_int;
                    act_frac <= next_frac;
                    pending  <= 1'b0;
                    lim      <= next_int - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
                end
            end

            // A load on a wrap/resync edge lands in the shadow after that
            // edge consumed the old shadow, so it waits for the next wrap.
            if (bus.i_load && load_ok) begin
                sh_int  <= bus.i_div_int;
                sh_frac <= bus.i_div_frac;
                pending <= 1'b1;
            end
        end
    end

    assign bus.o_os_tick  = os_tick;
    assign bus.o_bit_tick = bit_tick;
    assign bus.o_cfg_err  = cfg_err;
    assign bus.o_pending  = pending;
    assign bus.o_div_int  = act_int;
    assign bus.o_div_frac = act_frac;
endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb_uart_baud_tick_gen
// Scoreboarded bench for uart_baud_tick_gen. The reference model tracks the
// remaining cycles of the current oversample period and an integer fraction
// accumulator; predicted ticks go into a queue that a negedge monitor drains.
module tb_uart_baud_tick_gen;
    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
    localparam int OS = 16;
    localparam int FSCALE = 1 << FRAC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
        .DEFAULT_INT(162), .DEFAULT_FRAC(12)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    typedef struct {
        int cyc;
        bit bit_t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 0;

    // reference model state
    int m_int, m_frac, m_sh_int, m_sh_frac, m_rem, m_acc, m_os;
    bit m_pend;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // monitor: compares every presented tick against the scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL os_tick_missing: got 0 expected 1 at cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.o_os_tick === 1'b1) begin
                checks++;
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    if (bus.o_bit_tick !== q[0].bit_t) begin
                        errors++;
                        $display("FAIL bit_tick: got %0b expected %0b at cycle %0d",
                                 bus.o_bit_tick, q[0].bit_t, cyc);
                    end
                    void'(q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL os_tick_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end
            end else if (bus.o_os_tick !== 1'b0 || bus.o_bit_tick !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL tick_idle: got os=%0b bit=%0b expected 0 0 at cycle %0d",
                         bus.o_os_tick, bus.o_bit_tick, cyc);
            end
        end
    end

    task automatic model_reset();
        m_int = 162; m_frac = 12; m_sh_int = 162; m_sh_frac = 12;
        m_pend = 0; m_rem = 162; m_acc = 0; m_os = 0;
    endtask

    task automatic apply_pending();
        if (m_pend) begin
            m_int  = m_sh_int;
            m_frac = m_sh_frac;
        end
        m_pend = 0;
    endtask

    task automatic step(input bit en, input bit rs, input bit ld, input int di, input int df);
        bit   exp_err;
        int   carry;
        exp_t e;
        bus.i_enable   = en;
        bus.i_resync   = rs;
        bus.i_load     = ld;
        bus.i_div_int  = DIV_W'(di);
        bus.i_div_frac = FRAC_W'(df);
        exp_err = 0;
        if (rs) begin
            apply_pending();
            m_rem = m_int; m_acc = 0; m_os = 0;
        end else if (en) begin
            m_rem--;
            if (m_rem == 0) begin
                e.cyc   = cyc + 1;
                e.bit_t = (m_os == OS - 1);
                q.push_back(e);
                m_os  = (m_os + 1) % OS;
                m_acc = m_acc + m_frac;
                carry = m_acc / FSCALE;
                m_acc = m_acc % FSCALE;
                apply_pending();
                m_rem = m_int + carry;
            end
        end
        if (ld) begin
            if (di >= 2) begin
                m_sh_int = di; m_sh_frac = df; m_pend = 1;
            end else begin
                exp_err = 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("cfg_err",  int'(bus.o_cfg_err),  int'(exp_err));
        chk("pending",  int'(bus.o_pending),  int'(m_pend));
        chk("div_int",  int'(bus.o_div_int),  m_int);
        chk("div_frac", int'(bus.o_div_frac), m_frac);
    endtask

    task automatic run(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic run_until_rem(input int k);
        int guard = 0;
        while (m_rem != k && guard < 2000) begin
            step(1, 0, 0, 0, 0);
            guard++;
        end
        if (m_rem != k) chk("rem_reach", m_rem, k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_enable = 0; bus.i_resync = 0; bus.i_load = 0;
        bus.i_div_int = '0; bus.i_div_frac = '0;
        @(posedge clk);
        cyc++;
        model_reset();
        q.delete();
        #1;
        rst = 1'b0;
        chk("rst_os_tick",  int'(bus.o_os_tick),  0);
        chk("rst_bit_tick", int'(bus.o_bit_tick), 0);
        chk("rst_cfg_err",  int'(bus.o_cfg_err),  0);
        chk("rst_pending",  int'(bus.o_pending),  0);
        chk("rst_div_int",  int'(bus.o_div_int),  162);
        chk("rst_div_frac", int'(bus.o_div_frac), 12);
    endtask

    initial begin
        bus.i_enable = 0; bus.i_resync = 0; bus.i_load = 0;
        bus.i_div_int = '0; bus.i_div_frac = '0;
        model_reset();
        do_reset();
        mon_on = 1;

        // default divisor 162 + 12/16, at least 16 oversample periods and one bit tick
        run(2700);

        // reload mid-period to 4/0
        run_until_rem(80);
        step(1, 0, 1, 4, 0);
        run(400);

        // illegal loads
        step(1, 0, 1, 1, 5);
        run(3);
        step(1, 0, 1, 0, 5);
        run(20);

        // enable gap of 7 cycles at cnt==3 with int=10
        step(1, 0, 1, 10, 0);
        run(30);
        run_until_rem(7);
        repeat (7) step(0, 0, 0, 0, 0);
        run(40);

        // resync on the wrap edge, then ride out a full bit period
        run_until_rem(1);
        step(1, 1, 0, 0, 0);
        run(200);

        // resync with a pending load
        step(1, 0, 1, 6, 3);
        run_until_rem(5);
        step(1, 1, 0, 0, 0);
        run(200);

        // load coinciding with a wrap
        run_until_rem(1);
        step(1, 0, 1, 7, 5);
        run(100);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 14)),
                 int'($urandom_range(0, 15)));
        end
        run(50);

        // reset mid-operation discards a pending load
        step(1, 0, 1, 5, 0);
        run(2);
        do_reset();
        run(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
